// File: rtl/sm83_oam_dma_arb.sv
// SM83 external bus arbiter with the OAM DMA sequencer behind the 0xFF46 source register.
// FSM advances only on t4 edges; all bus outputs are combinational from state and core inputs.
module sm83_oam_dma_arb #(
  parameter int          XFER_LEN = 160,
  parameter logic [15:0] DMA_REG  = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        t1,
  input  logic        t2,
  input  logic        t3,
  input  logic        t4,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_din,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, XFER, RESTART} state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_eff;
  logic       dma_reg_wr, io_sel, xfer;

  // Only the M-cycle position strobe t4 matters; the other phases are informational.
  logic unused_phase;
  assign unused_phase = &{1'b0, t1, t2, t3};

  assign dma_reg_wr = cpu_wr && (cpu_addr == DMA_REG);
  assign io_sel     = (cpu_addr[15:8] == 8'hFF);
  assign xfer       = (state_q == XFER);
  // Sources in echo RAM / OAM / IO space fold back onto work RAM.
  assign src_eff    = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= 8'hFF;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    if (t4) begin
      if (dma_reg_wr) begin
        src_d   = cpu_dout;
        idx_d   = '0;
        state_d = (state_q == IDLE) ? START : RESTART;
      end else begin
        case (state_q)
          START, RESTART: begin
            state_d = XFER;
            idx_d   = '0;
          end
          XFER: begin
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dma_active = (state_q == XFER) || (state_q == RESTART);
    ext_addr   = xfer ? {src_eff, idx_q} : cpu_addr;
    ext_dout   = cpu_dout;
    ext_rd     = 1'b0;
    ext_wr     = 1'b0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    cpu_din    = 8'hFF;
    oam_addr   = idx_q;
    oam_wdata  = ext_din;
    oam_we     = xfer && t4;
    if (io_sel) begin
      io_rd   = cpu_rd;
      io_wr   = cpu_wr;
      cpu_din = (cpu_addr == DMA_REG) ? src_q : io_din;
    end else if (!dma_active) begin
      ext_rd  = cpu_rd;
      ext_wr  = cpu_wr;
      cpu_din = ext_din;
    end
    if (xfer) ext_rd = 1'b1;
    // Strobes must be quiet while reset is held, whatever the core is asserting.
    if (!reset_n) begin
      ext_rd = 1'b0;
      ext_wr = 1'b0;
      io_rd  = 1'b0;
      io_wr  = 1'b0;
      oam_we = 1'b0;
    end
  end
endmodule
